// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Program-counter fetch stage: fetches one word at a time, presents PC/instr,
// advances on consumption and halts with a sticky fault on misalignment or timeout.
module pc_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCsrc,
  input  logic [31:0]       ImmOp,
  input  logic              stall,
  pc_fetch_if.master        imem,
  output logic [31:0]       PC,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       instret,
  output logic [1:0]        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int unsigned WW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instret_q, instret_d;
  logic [1:0]    fault_q, fault_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          req_q, valid_q;
  logic [31:0]   next_pc_s;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    next_pc_s = pc_q + (PCsrc ? ImmOp : 32'd4);
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 2'b10;
          state_d = HALT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      VALID: begin
        if (!stall) begin
          instret_d = instret_q + 32'd1;
          // A misaligned target is reported without ever becoming the PC.
          if (next_pc_s[1:0] == 2'b00) begin
            pc_d    = next_pc_s;
            wait_d  = '0;
            state_d = FETCH;
          end else begin
            fault_d = 2'b01;
            state_d = HALT;
          end
        end else begin
          state_d = VALID;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State and output registers; strobes are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= 32'd0;
      fault_q   <= 2'b00;
      wait_q    <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      req_q     <= (state_d == FETCH);
      valid_q   <= (state_d == VALID);
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign PC             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign instret        = instret_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized self-checking bench for pc_fetch against a transaction-level model.
module tb_pc_fetch;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] imm = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] pc_o, instr_o, instret_o;
  logic        instr_valid_o;
  logic [1:0]  fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch stage should be showing right now.
  logic [31:0] m_pc, m_instr, m_instret;
  logic [1:0]  m_fault;
  bit          m_idle, m_fetch, m_valid;
  int          m_wait;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrc      (pcsrc),
    .ImmOp      (imm),
    .stall      (stall),
    .imem       (bus),
    .PC         (pc_o),
    .instr      (instr_o),
    .instr_valid(instr_valid_o),
    .instret    (instret_o),
    .fault      (fault_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},      pc_o, m_pc);
    check_eq({tag, ".addr"},    bus.imem_addr, m_pc);
    check_eq({tag, ".req"},     {31'd0, bus.imem_req}, {31'd0, m_fetch});
    check_eq({tag, ".valid"},   {31'd0, instr_valid_o}, {31'd0, m_valid});
    check_eq({tag, ".instr"},   instr_o, m_instr);
    check_eq({tag, ".instret"}, instret_o, m_instret);
    check_eq({tag, ".fault"},   {30'd0, fault_o}, {30'd0, m_fault});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0000_0013; m_instret = 32'd0; m_fault = 2'b00;
    m_idle = 1'b1; m_fetch = 1'b0; m_valid = 1'b0; m_wait = 0;
  endtask

  task automatic model_step(input logic pc_sel, input logic [31:0] off, input logic hold,
                            input logic rdy, input logic [31:0] rdata);
    logic [31:0] nxt;
    if (m_idle) begin
      m_idle = 1'b0; m_fetch = 1'b1; m_wait = 0;
    end else if (m_fetch) begin
      if (rdy) begin
        m_instr = rdata; m_fetch = 1'b0; m_valid = 1'b1;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) begin m_fetch = 1'b0; m_fault = 2'b10; end
      end
    end else if (m_valid && !hold) begin
      nxt = m_pc + (pc_sel ? off : 32'd4);
      m_instret = m_instret + 32'd1;
      m_valid = 1'b0;
      if (nxt[1:0] == 2'b00) begin
        m_pc = nxt; m_fetch = 1'b1; m_wait = 0;
      end else begin
        m_fault = 2'b01;
      end
    end
  endtask

  function automatic bit model_halted();
    return !m_idle && !m_fetch && !m_valid;
  endfunction

  // Called with time just past a falling edge; reset goes in asynchronously.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  task automatic step(input logic pc_sel, input logic [31:0] off, input logic hold,
                      input logic rdy, input logic [31:0] rdata);
    pcsrc = pc_sel; imm = off; stall = hold;
    bus.imem_ready = rdy; bus.imem_rdata = rdata;
    model_step(pc_sel, off, hold, rdy, rdata);
    @(posedge clk);
    @(negedge clk);
    check_all("step");
  endtask

  initial begin
    logic [31:0] saved;
    int drought, halt_cycles, d;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    do_reset();

    // Straight-line fetch of NOPs: PC 0,4,8, valid in the third cycle.
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h13);
    check_eq("idle_no_valid", {31'd0, instr_valid_o}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h13);
    check_eq("first_valid", {31'd0, instr_valid_o}, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h13);
    check_eq("pc_4", pc_o, 32'h4);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h13);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h13);
    check_eq("pc_8", pc_o, 32'h8);
    check_eq("instret_2", instret_o, 32'd2);

    // Branch forward to 0x10, then backward by 8.
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_0001);
    step(1'b1, 32'd8, 1'b0, 1'b0, 32'h0);
    check_eq("br_fwd", pc_o, 32'h10);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h2222_0002);
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0);
    check_eq("br_back_addr", bus.imem_addr, 32'h8);

    // Stall five cycles in VALID with noisy inputs, then one advance.
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h3333_0003);
    saved = instret_o;
    for (int i = 0; i < 5; i++) step(1'($urandom), $urandom, 1'b1, 1'($urandom), $urandom);
    check_eq("stall_pc", pc_o, 32'h8);
    check_eq("stall_instr", instr_o, 32'h3333_0003);
    check_eq("stall_instret", instret_o, saved);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    check_eq("stall_release", pc_o, 32'hC);

    // Wrap through the top of the address space.
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h4444_0004);
    step(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0);
    check_eq("to_top", pc_o, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h5555_0005);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc", pc_o, 32'h0);
    check_eq("wrap_fault", {30'd0, fault_o}, 32'd0);

    // Fetch timeout: still requesting after 14 idle cycles, halted after 15.
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 32'd0, 1'b0, 1'b0, $urandom);
    check_eq("to_still_req", {31'd0, bus.imem_req}, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0, $urandom);
    check_eq("to_fault", {30'd0, fault_o}, 32'h2);
    check_eq("to_req", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'($urandom), $urandom, 1'b0, 1'b1, $urandom);

    // Misaligned branch target halts with PC untouched; reset recovers.
    @(negedge clk);
    check_all("pre_rst");
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h6666_0006);
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'h6666_0006);
    step(1'b1, 32'd2, 1'b0, 1'b1, 32'h0);
    check_eq("mis_fault", {30'd0, fault_o}, 32'h1);
    check_eq("mis_pc", pc_o, 32'h0);
    do_reset();
    check_eq("rst_instr", instr_o, 32'h0000_0013);
    check_eq("rst_fault", {30'd0, fault_o}, 32'd0);

    // Random traffic with occasional droughts, misaligned branches and resets.
    drought = 0;
    halt_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] off;
      logic rdy;
      d = $urandom_range(0, 63);
      off = 32'((d - 32) * 4);
      if ($urandom_range(0, 15) == 0) off = off + 32'($urandom_range(1, 3));
      if (drought == 0 && $urandom_range(0, 99) == 0) drought = $urandom_range(10, 20);
      if (drought > 0) begin
        rdy = 1'b0;
        drought--;
      end else begin
        rdy = ($urandom_range(0, 9) < 7);
      end
      step(1'($urandom), off, ($urandom_range(0, 9) < 3), rdy, $urandom);
      if (model_halted()) halt_cycles++;
      if (halt_cycles > 3 || $urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
        halt_cycles = 0;
        drought = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
